// File: rtl/iob_riffa_pkg.sv
// Shared definitions for the RIFFA channel host: default widths and FSM state types.
package iob_riffa_pkg;

  localparam int unsigned DATA_W_DEF      = 64;
  localparam int unsigned LEN_W_DEF       = 32;
  localparam int unsigned ACK_TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_REQ,
    RX_DATA,
    RX_DONE
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_ACK,
    TX_DATA,
    TX_WAITLOW
  } tx_state_t;

endpackage

// File: rtl/iob_riffa_skid.sv
// One-entry valid/ready register: accepts a new beat whenever it is empty or being drained.
module iob_riffa_skid
  import iob_riffa_pkg::*;
#(
  parameter int unsigned W = DATA_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  assign in_ready = !out_valid || out_ready;

  // Load on input handshake, otherwise empty once the held beat is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/iob_riffa_chnl_host.sv
// Host side of a RIFFA channel: RX pushes source beats to the endpoint,
// TX collects endpoint beats into a sink. The two directions are independent.
module iob_riffa_chnl_host
  import iob_riffa_pkg::*;
#(
  parameter int unsigned C_PCI_DATA_WIDTH = DATA_W_DEF,
  parameter int unsigned LEN_W            = LEN_W_DEF,
  parameter int unsigned ACK_TIMEOUT      = ACK_TIMEOUT_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        RX_START_i,
  input  logic [LEN_W-1:0]            RX_LEN_i,
  input  logic                        RX_LAST_i,
  input  logic [C_PCI_DATA_WIDTH-1:0] SRC_DATA_i,
  input  logic                        SRC_VALID_i,
  output logic                        SRC_READY_o,
  output logic [C_PCI_DATA_WIDTH-1:0] SNK_DATA_o,
  output logic                        SNK_VALID_o,
  input  logic                        SNK_READY_i,
  output logic [LEN_W-1:0]            SNK_LEN_o,
  output logic                        SNK_DONE_o,
  output logic                        RX_BUSY_o,
  output logic                        TX_BUSY_o,
  output logic                        RX_ERR_o,
  output logic                        CHNL_RX_o,
  output logic                        CHNL_RX_LAST_o,
  output logic [LEN_W-1:0]            CHNL_RX_LEN_o,
  output logic [30:0]                 CHNL_RX_OFF_o,
  output logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA_o,
  output logic                        CHNL_RX_DATA_VALID_o,
  input  logic                        CHNL_RX_DATA_REN_i,
  input  logic                        CHNL_RX_ACK_i,
  input  logic                        CHNL_TX_i,
  input  logic                        CHNL_TX_LAST_i,
  input  logic [LEN_W-1:0]            CHNL_TX_LEN_i,
  input  logic [30:0]                 CHNL_TX_OFF_i,
  input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA_i,
  input  logic                        CHNL_TX_DATA_VALID_i,
  output logic                        CHNL_TX_DATA_REN_o,
  output logic                        CHNL_TX_ACK_o
);

  localparam int unsigned TO_W = $clog2(ACK_TIMEOUT + 1);

  // Two 32-bit words per beat; an odd length rounds up.
  function automatic logic [LEN_W-1:0] beats(input logic [LEN_W-1:0] len);
    return (len >> 1) + {{(LEN_W-1){1'b0}}, len[0]};
  endfunction

  // ---------------- RX: host to endpoint ----------------
  rx_state_t        rx_state;
  logic [LEN_W-1:0] rx_src_left;
  logic [LEN_W-1:0] rx_beat_left;
  logic [TO_W-1:0]  rx_to_cnt;
  logic             rx_in_ready;
  logic             rx_src_ok;
  logic             rx_consume;

  assign rx_src_ok     = (rx_state == RX_DATA) && (rx_src_left != '0);
  assign SRC_READY_o   = rx_src_ok && rx_in_ready;
  assign rx_consume    = CHNL_RX_DATA_VALID_o && CHNL_RX_DATA_REN_i;
  assign RX_BUSY_o     = (rx_state != RX_IDLE);
  assign CHNL_RX_OFF_o = '0;

  iob_riffa_skid #(.W(C_PCI_DATA_WIDTH)) u_rx_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (SRC_DATA_i),
    .in_valid  (SRC_VALID_i && rx_src_ok),
    .in_ready  (rx_in_ready),
    .out_data  (CHNL_RX_DATA_o),
    .out_valid (CHNL_RX_DATA_VALID_o),
    .out_ready (CHNL_RX_DATA_REN_i)
  );

  // RX request/ack handshake, ack timeout and beat accounting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state       <= RX_IDLE;
      rx_src_left    <= '0;
      rx_beat_left   <= '0;
      rx_to_cnt      <= '0;
      RX_ERR_o       <= 1'b0;
      CHNL_RX_o      <= 1'b0;
      CHNL_RX_LAST_o <= 1'b0;
      CHNL_RX_LEN_o  <= '0;
    end else begin
      RX_ERR_o <= 1'b0;
      unique case (rx_state)
        RX_IDLE: if (RX_START_i) begin
          CHNL_RX_LEN_o  <= RX_LEN_i;
          CHNL_RX_LAST_o <= RX_LAST_i;
          CHNL_RX_o      <= 1'b1;
          rx_to_cnt      <= '0;
          rx_state       <= RX_REQ;
        end
        RX_REQ: begin
          if (CHNL_RX_ACK_i) begin
            rx_src_left  <= beats(CHNL_RX_LEN_o);
            rx_beat_left <= beats(CHNL_RX_LEN_o);
            if (CHNL_RX_LEN_o == '0) begin
              CHNL_RX_o <= 1'b0;
              rx_state  <= RX_DONE;
            end else begin
              rx_state <= RX_DATA;
            end
          end else if (rx_to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
            RX_ERR_o  <= 1'b1;
            CHNL_RX_o <= 1'b0;
            rx_state  <= RX_IDLE;
          end else begin
            rx_to_cnt <= rx_to_cnt + TO_W'(1);
          end
        end
        RX_DATA: begin
          if (SRC_READY_o && SRC_VALID_i)
            rx_src_left <= rx_src_left - LEN_W'(1);
          if (rx_consume && (rx_beat_left != '0)) begin
            rx_beat_left <= rx_beat_left - LEN_W'(1);
            if (rx_beat_left == LEN_W'(1)) begin
              CHNL_RX_o <= 1'b0;
              rx_state  <= RX_DONE;
            end
          end
        end
        RX_DONE: rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- TX: endpoint to host sink ----------------
  tx_state_t        tx_state;
  logic [LEN_W-1:0] tx_cap_left;
  logic [LEN_W-1:0] tx_drain_left;
  logic             tx_in_ready;
  logic             tx_cap_ok;
  logic             unused_tx;

  assign tx_cap_ok          = (tx_state == TX_DATA) && (tx_cap_left != '0);
  assign CHNL_TX_DATA_REN_o = tx_cap_ok && tx_in_ready;
  assign TX_BUSY_o          = (tx_state != TX_IDLE);
  // Endpoint offset and last flag carry nothing this host acts on.
  assign unused_tx          = ^{CHNL_TX_OFF_i, CHNL_TX_LAST_i};

  iob_riffa_skid #(.W(C_PCI_DATA_WIDTH)) u_tx_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (CHNL_TX_DATA_i),
    .in_valid  (CHNL_TX_DATA_VALID_i && tx_cap_ok),
    .in_ready  (tx_in_ready),
    .out_data  (SNK_DATA_o),
    .out_valid (SNK_VALID_o),
    .out_ready (SNK_READY_i)
  );

  // TX ack pulse, capture/drain counting and done pulse on the final drained beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state      <= TX_IDLE;
      tx_cap_left   <= '0;
      tx_drain_left <= '0;
      SNK_LEN_o     <= '0;
      SNK_DONE_o    <= 1'b0;
      CHNL_TX_ACK_o <= 1'b0;
    end else begin
      SNK_DONE_o    <= 1'b0;
      CHNL_TX_ACK_o <= 1'b0;
      unique case (tx_state)
        TX_IDLE: if (CHNL_TX_i) begin
          SNK_LEN_o     <= CHNL_TX_LEN_i;
          tx_cap_left   <= beats(CHNL_TX_LEN_i);
          tx_drain_left <= beats(CHNL_TX_LEN_i);
          CHNL_TX_ACK_o <= 1'b1;
          tx_state      <= TX_ACK;
        end
        TX_ACK: begin
          if (tx_drain_left == '0) begin
            SNK_DONE_o <= 1'b1;
            tx_state   <= TX_WAITLOW;
          end else begin
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (CHNL_TX_DATA_REN_o && CHNL_TX_DATA_VALID_i)
            tx_cap_left <= tx_cap_left - LEN_W'(1);
          if (SNK_VALID_o && SNK_READY_i && (tx_drain_left != '0)) begin
            tx_drain_left <= tx_drain_left - LEN_W'(1);
            if (tx_drain_left == LEN_W'(1)) begin
              SNK_DONE_o <= 1'b1;
              tx_state   <= TX_WAITLOW;
            end
          end
        end
        TX_WAITLOW: if (!CHNL_TX_i) tx_state <= TX_IDLE;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule
